// File: rtl/pipe_mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the execute stage; owns HI/LO.
// Runs a 32-step shift-add multiply or restoring divide on operand magnitudes.
module pipe_mdu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       emdop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             ecancel,
  output logic             mdu_stall,
  output logic             mdu_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   acc_q;    // multiply: upper product / divide: remainder
  logic [WIDTH-1:0]   lsw_q;    // multiply: multiplier / divide: quotient
  logic [WIDTH-1:0]   opb_q;    // multiply: multiplicand / divide: divisor
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, neg_q_q, neg_r_q;

  logic               start_c, is_signed_c, is_div_c, sgn_fix_c;
  logic [WIDTH-1:0]   abs_a_c, abs_b_c;
  logic [WIDTH:0]     mul_sum_c, div_shift_c, div_trial_c;
  logic [WIDTH-1:0]   acc_d, lsw_d;
  logic [2*WIDTH-1:0] prod_c, prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

  // Start decode and operand magnitudes; a signed divide by zero keeps raw operands
  always_comb begin
    start_c     = !ecancel && (emdop == OP_MULT || emdop == OP_MULTU ||
                               emdop == OP_DIV  || emdop == OP_DIVU);
    is_signed_c = (emdop == OP_MULT) || (emdop == OP_DIV);
    is_div_c    = (emdop == OP_DIV)  || (emdop == OP_DIVU);
    sgn_fix_c   = is_signed_c && !(is_div_c && (eb == '0));
    abs_a_c     = (sgn_fix_c && ea[WIDTH-1]) ? WIDTH'(-ea) : ea;
    abs_b_c     = (sgn_fix_c && eb[WIDTH-1]) ? WIDTH'(-eb) : eb;
  end

  // One multiply or divide iteration
  always_comb begin
    mul_sum_c   = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, opb_q} : '0);
    div_shift_c = {acc_q, lsw_q[WIDTH-1]};
    div_trial_c = div_shift_c - {1'b0, opb_q};
    acc_d       = mul_sum_c[WIDTH:1];
    lsw_d       = {mul_sum_c[0], lsw_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (!div_trial_c[WIDTH]) begin
        acc_d = div_trial_c[WIDTH-1:0];
        lsw_d = {lsw_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift_c[WIDTH-1:0];
        lsw_d = {lsw_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up applied at commit
  always_comb begin
    prod_c     = {acc_q, lsw_q};
    prod_fix_c = neg_q_q ? (2*WIDTH)'(-prod_c) : prod_c;
    quo_fix_c  = neg_q_q ? WIDTH'(-lsw_q) : lsw_q;
    rem_fix_c  = neg_r_q ? WIDTH'(-acc_q) : acc_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      lsw_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            acc_q    <= '0;
            lsw_q    <= is_div_c ? abs_a_c : abs_b_c;
            opb_q    <= is_div_c ? abs_b_c : abs_a_c;
            is_div_q <= is_div_c;
            neg_q_q  <= sgn_fix_c && (ea[WIDTH-1] ^ eb[WIDTH-1]);
            neg_r_q  <= sgn_fix_c && ea[WIDTH-1];
            count_q  <= '0;
            state_q  <= S_RUN;
          end else if (!ecancel && emdop == OP_MTHI) begin
            hi_q <= ea;
          end else if (!ecancel && emdop == OP_MTLO) begin
            lo_q <= ea;
          end
        end
        S_RUN: begin
          if (ecancel) begin
            state_q <= S_IDLE;
          end else begin
            acc_q   <= acc_d;
            lsw_q   <= lsw_d;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!ecancel) begin
            if (is_div_q) begin
              hi_q <= rem_fix_c;
              lo_q <= quo_fix_c;
            end else begin
              hi_q <= prod_fix_c[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix_c[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall is combinational so the start cycle itself holds the pipeline
  assign mdu_stall = !reset && ((state_q == S_IDLE && start_c) || state_q == S_RUN);
  assign mdu_busy  = (state_q != S_IDLE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Self-checking bench for pipe_mdu_ctrl: directed corner cases plus random ops
// checked against an arithmetic HI/LO model.
module tb_pipe_mdu_ctrl;

  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3;
  localparam logic [2:0] DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clock = 1'b0;
  logic        reset, ecancel;
  logic [2:0]  emdop;
  logic [31:0] ea, eb;
  logic        mdu_stall, mdu_busy;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mhi = '0, mlo = '0;

  always #5 clock = ~clock;

  pipe_mdu_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .emdop(emdop), .ea(ea), .eb(eb),
    .ecancel(ecancel), .mdu_stall(mdu_stall), .mdu_busy(mdu_busy),
    .hi(hi), .lo(lo)
  );

  // Architectural HI/LO effect of one op, from plain arithmetic
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MULT:  begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
      MULTU: begin p = {32'h0, a} * {32'h0, b}; mhi = p[63:32]; mlo = p[31:0]; end
      DIV:   if (b == 0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
             else begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      DIVU:  if (b == 0) begin mlo = 32'hFFFF_FFFF; mhi = a; end
             else begin mlo = a / b; mhi = a % b; end
      MTHI:  mhi = a;
      MTLO:  mlo = a;
      default: ;
    endcase
  endtask

  // Present an op in EX until it leaves, scrambling operands while it runs
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stall_n);
    @(negedge clock);
    emdop = op; ea = a; eb = b; stall_n = 0;
    #1;
    while (mdu_stall === 1'b1 && stall_n < 100) begin
      stall_n++;
      @(negedge clock);
      ea = $urandom; eb = $urandom;
      #1;
    end
    @(negedge clock);
    emdop = NOP;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; ecancel = 1'b0; emdop = MULT; ea = 32'd5; eb = 32'd6;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", mdu_stall); end
    n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
    @(negedge clock);
    reset = 1'b0; emdop = NOP;
    mhi = '0; mlo = '0;
  endtask

  task automatic test_directed;
    logic [2:0]  t_op  [6] = '{MULT, MULTU, DIV, DIVU, DIV, DIV};
    logic [31:0] t_a   [6] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] t_b   [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_hi  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd100, 32'h0, 32'hFFFF_FFFB};
    logic [31:0] t_lo  [6] = '{32'hFFFF_FFEB, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int n;
    for (int i = 0; i < 6; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], n);
      n_checks++; if (n != 33) begin n_fail++; $display("FAIL dir%0d_stall_cycles: got %0d want 33", i, n); end
      n_checks++; if (hi !== t_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, t_hi[i]); end
      n_checks++; if (lo !== t_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, t_lo[i]); end
      n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy: got %b want 0", i, mdu_busy); end
      mhi = t_hi[i]; mlo = t_lo[i];
    end
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clock);
    emdop = MTHI; ea = 32'h1234_5678; #1;
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: got %b want 0", mdu_stall); end
    @(negedge clock);
    emdop = MTLO; ea = 32'h9; #1;
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall: got %b want 0", mdu_stall); end
    @(negedge clock);
    emdop = NOP; #1;
    mhi = 32'h1234_5678; mlo = 32'h9;
    n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL mt_hi: got %h want %h", hi, mhi); end
    n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL mt_lo: got %h want %h", lo, mlo); end
    // Cancelled starts and moves are dropped
    @(negedge clock);
    emdop = DIV; ea = 32'd50; eb = 32'd7; ecancel = 1'b1; #1;
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_stall: got %b want 0", mdu_stall); end
    @(negedge clock);
    emdop = MTHI; ea = 32'hDEAD_BEEF; #1;
    n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_busy: got %b want 0", mdu_busy); end
    @(negedge clock);
    emdop = NOP; ecancel = 1'b0; #1;
    n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL cancel_mthi_hi: got %h want %h", hi, mhi); end
  endtask

  task automatic test_cancel;
    int n;
    do_op(MTHI, 32'hA, 32'h0, n);
    do_op(MTLO, 32'hB, 32'h0, n);
    mhi = 32'hA; mlo = 32'hB;
    @(negedge clock);
    emdop = DIV; ea = 32'd1000; eb = 32'd3;
    repeat (10) @(negedge clock);
    ecancel = 1'b1; #1;
    n_checks++; if (mdu_stall !== 1'b1) begin n_fail++; $display("FAIL cancel_run_stall: got %b want 1", mdu_stall); end
    @(negedge clock);
    ecancel = 1'b0; emdop = NOP; #1;
    n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", mdu_busy); end
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL cancel_stall: got %b want 0", mdu_stall); end
    n_checks++; if (hi !== 32'hA) begin n_fail++; $display("FAIL cancel_hi: got %h want 0000000a", hi); end
    n_checks++; if (lo !== 32'hB) begin n_fail++; $display("FAIL cancel_lo: got %h want 0000000b", lo); end
    do_op(MULT, 32'd3, 32'd4, n);
    mhi = 32'h0; mlo = 32'd12;
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL post_cancel_stall_cycles: got %0d want 33", n); end
    n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL post_cancel_hi: got %h want %h", hi, mhi); end
    n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL post_cancel_lo: got %h want %h", lo, mlo); end
    // Cancel landing in the commit cycle must not write HI/LO
    @(negedge clock);
    emdop = MULTU; ea = 32'hFFFF; eb = 32'hFFFF; n = 0; #1;
    while (mdu_stall === 1'b1 && n < 100) begin n++; @(negedge clock); #1; end
    ecancel = 1'b1;
    @(negedge clock);
    ecancel = 1'b0; emdop = NOP; #1;
    n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL done_cancel_lo: got %h want %h", lo, mlo); end
    n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL done_cancel_busy: got %b want 0", mdu_busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clock);
    emdop = MULTU; ea = 32'h8765_4321; eb = 32'h0001_0003; n = 0; #1;
    while (mdu_stall === 1'b1 && n < 100) begin n++; @(negedge clock); #1; end
    @(negedge clock);
    emdop = DIVU; ea = 32'd123_456_789; eb = 32'd1000; #1;
    model_op(MULTU, 32'h8765_4321, 32'h0001_0003);
    n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL b2b_first_hi: got %h want %h", hi, mhi); end
    n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL b2b_first_lo: got %h want %h", lo, mlo); end
    n_checks++; if (mdu_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_stall: got %b want 1", mdu_stall); end
    n = 0;
    while (mdu_stall === 1'b1 && n < 100) begin n++; @(negedge clock); #1; end
    @(negedge clock);
    emdop = NOP; #1;
    model_op(DIVU, 32'd123_456_789, 32'd1000);
    n_checks++; if (n != 33) begin n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 33", n); end
    n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL b2b_second_hi: got %h want %h", hi, mhi); end
    n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL b2b_second_lo: got %h want %h", lo, mlo); end
  endtask

  task automatic test_random;
    logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      do_op(op, a, b, n);
      model_op(op, a, b);
      n_checks++;
      if (n != ((op >= MTHI) ? 0 : 33)) begin
        n_fail++; $display("FAIL rnd%0d_stall_cycles op=%0d: got %0d", i, op, n);
      end
      n_checks++; if (hi !== mhi) begin n_fail++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, op, a, b, hi, mhi); end
      n_checks++; if (lo !== mlo) begin n_fail++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, op, a, b, lo, mlo); end
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    do_op(MTHI, 32'h5555_AAAA, 32'h0, n);
    @(negedge clock);
    emdop = DIV; ea = 32'hF000_0000; eb = 32'd9;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midrun_reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midrun_reset_lo: got %h want 0", lo); end
    n_checks++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b want 0", mdu_busy); end
    n_checks++; if (mdu_stall !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_stall: got %b want 0", mdu_stall); end
    reset = 1'b0; emdop = NOP;
    mhi = '0; mlo = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_cancel();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mdu_ctrl.md
Name: pipe_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer attached to the pipeline execute stage. Owns the HI/LO architectural registers.
- Decodes the EX-stage mult/div opcode and runs a 32-iteration shift-add multiply or restoring divide on the EX operands.
- Stalls IF/ID/EX until the result is committed to HI/LO. The EX result mux reads HI/LO for mfhi/mflo.

Parameters:
- WIDTH, 32, operand/HI/LO width. Only 32 is supported.
- CNT_W, 5, iteration counter width, log2(WIDTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- emdop  in  3  EX-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
- ea  in  WIDTH  EX operand A (rs); dividend / multiplicand / mthi-mtlo data.
- eb  in  WIDTH  EX operand B (rt); divisor / multiplier.
- ecancel  in  1  flush of the EX instruction (exception/redirect).
- mdu_stall  out  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- mdu_busy  out  1  state != IDLE.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, checked before all else): state=IDLE, count=0, hi=0, lo=0, internal accumulators=0, mdu_busy=0, mdu_stall=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - emdop in {mult, multu, div, divu} and !ecancel → start.
    - Latch |ea| and |eb|. For unsigned ops, take the raw values.
    - Latch neg_q = signed & (ea[31]^eb[31]) and neg_r = signed & ea[31].
    - Set count=0 and go to RUN.
    - mdu_stall=1 combinationally in this cycle.
  - mthi/mtlo with !ecancel: hi (or lo) <= ea at the clock edge. No stall; stay in IDLE.
  - none/reserved, or ecancel=1: no state change.
- RUN:
  - One iteration per cycle.
  - Multiply: 64-bit {acc, mplr} shift-add; if mplr[0], add mcand to the upper 33 bits; then shift right 1.
  - Divide: restoring. Shift {rem, quo} left 1; trial = rem - divisor (33-bit); if non-negative, rem = trial and quo[0] = 1.
  - count increments. On count==31, go to DONE.
  - mdu_stall=1 throughout.
- DONE:
  - At the edge, apply sign fix-up and write hi/lo.
    - Multiply: {hi, lo} = neg_q ? -{acc, mplr} (64-bit two's complement) : {acc, mplr}.
    - Divide: lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem.
  - mdu_stall=0 so the instruction leaves EX. Go to IDLE.
  - emdop is ignored in DONE; the same op is still present and must not restart.
- Latency: op enters EX in cycle t.
  - mdu_stall is high in cycles t..t+32 (33 cycles) and low in t+33 (DONE).
  - hi/lo hold new values from t+34. A back-to-back mfhi/mflo entering EX at t+34 sees them.
- Divide by zero (eb==0), div and divu alike: lo=32'hFFFFFFFF, hi=ea. This falls out naturally for divu. For div, the fix-up is suppressed when eb==0 (detected at start).
- Signed overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- ecancel:
  - In RUN or DONE: go to IDLE next edge. hi/lo are unchanged and mdu_stall drops in the following cycle.
  - In IDLE with a start op: ignored (no start).
- Reset mid-RUN: return to IDLE and clear hi/lo to 0.
- Operands are sampled only at start; changes on ea/eb during RUN are ignored.

Test Plan:
- Reset: assert reset for 2 cycles, with an op present → hi=0, lo=0, mdu_stall=0, mdu_busy=0.
- mult ea=7, eb=0xFFFFFFFD → mdu_stall high exactly 33 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu ea=eb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div ea=0xFFFFFFF9 (-7), eb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu ea=100, eb=0 → lo=0xFFFFFFFF, hi=100.
- mthi ea=0x12345678, then mtlo ea=0x9 on consecutive cycles → no stall; hi=0x12345678, lo=0x9.
- ecancel asserted 10 cycles into a div (prior hi=0xA, lo=0xB):
  - state returns to IDLE next cycle and mdu_stall is low after that; hi=0xA, lo=0xB unchanged.
  - A following mult 3*4 gives hi=0, lo=12.
